volume_ramp_controller: RTL and testbench
=========================================

// Module: volume_ramp_controller
// PURPOSE
//  Sequences the volume/mute controls of the stereo output stage so gain changes are pop-free.
//  Takes user volume requests and a mute request, then ramps the applied volume in bounded steps
//  paced by the audio sample tick. Ramps to zero before asserting mute and ramps up after
//  unmuting. Sits between control logic (switches/registers) and output_stage_with_volume.
// PARAMETERS
//  VOL_W      8    width of volume request/output (unsigned)
//  TICK_DIV   16   sample ticks per volume step (>=1)
//  STEP       1    max volume change per step (1..2^VOL_W-1)
//  RESET_VOL  128  target volume loaded at reset
// PORTS
//  clk            in   1      system clock
//  reset          in   1      synchronous, active-high reset
//  sample_tick    in   1      one-cycle strobe at the audio sample rate
//  vol_req        in   VOL_W  requested volume
//  vol_req_valid  in   1      one-cycle strobe; latches vol_req into target (latest wins)
//  mute_req       in   1      level; 1 = mute requested
//  volume         out  VOL_W  applied volume to the output stage (registered)
//  mute           out  1      mute to the output stage (registered)
//  ramping        out  1      1 while state is RAMP, FADE_OUT or FADE_IN
// BEHAVIOUR
//  Reset (sync, overrides everything incl. mid-ramp): volume=0, mute=1, ramping=0, target=RESET_VOL,
//   div_cnt=0, state=MUTED.
//  States: IDLE (volume==target, mute=0) | RAMP (dest=target) | FADE_OUT (dest=0) | MUTED (mute=1)
//   | FADE_IN (dest=target). mute = (state==MUTED); all outputs change on the same edge.
//  Pacing: div_cnt counts sample_ticks 0..TICK_DIV-1 in ramp states. A step fires on a tick with
//   div_cnt==TICK_DIV-1, then div_cnt wraps to 0. div_cnt clears on entry from IDLE/MUTED.
//   div_cnt is NOT cleared on a direction change between ramp states.
//  Step: volume moves toward dest by min(STEP,|dest-volume|). No overshoot. No wrap below 0 or
//   above 2^VOL_W-1. The difference is computed at VOL_W+1 bits.
//  target: written the cycle after vol_req_valid, in every state. In RAMP/FADE_IN the new target
//   takes effect immediately as dest. In MUTED/FADE_OUT it is stored and used on the next fade-in.
//  Transitions (priority top-down within each state):
//   IDLE:     mute_req -> FADE_OUT; vol_req_valid && vol_req!=volume -> RAMP.
//   RAMP:     mute_req -> FADE_OUT from the current volume; volume==target after a step -> IDLE.
//   FADE_OUT: !mute_req -> FADE_IN (reverses from the current volume, no jump, mute stays 0);
//             the step that reaches volume==0 -> MUTED (volume 0 and mute 1 on the same edge).
//   MUTED:    !mute_req -> FADE_IN (mute drops on this edge, volume still 0).
//   FADE_IN:  mute_req -> FADE_OUT; volume==target -> IDLE (target 0 => IDLE the next cycle).
//   IDLE/FADE_OUT with volume already 0 and mute_req -> MUTED the next cycle, no tick needed.
//  Simultaneous events: mute_req outranks vol_req_valid. The new target is still latched.
//   A step and a target change in the same cycle: the step uses the old dest.
//  Latency: vol_req_valid@t -> target and RAMP @t+1. The first step happens on the TICK_DIV-th
//   sample_tick after that.
//  sample_tick is ignored in IDLE/MUTED. volume never changes in IDLE/MUTED.
//  Assertions: TICK_DIV>=1. STEP>=1. volume changes only on step cycles.
// STRUCTURE
//  volume_ctrl_pkg: state encoding localparams (IDLE, RAMP, FADE_OUT, MUTED, FADE_IN) and default VOL_W.
//   Shared with output_stage_with_volume users.
//  Sub-module tick_divider (TICK_DIV, inputs clear/tick, output step_en) holds div_cnt.
//   The FSM and saturating stepper stay in this module.
// TESTING  (bench config TICK_DIV=4, STEP=3, RESET_VOL=8, sample_tick every 2nd clk)
//  1 Release reset, mute_req=0 -> mute 1->0 next edge; volume 0,3,6,8 every 4 ticks; ramping 0 at 8.
//  2 In IDLE@8, vol_req=14 -> 11,14 then IDLE. Then vol_req=13 -> single step to 13 (no overshoot).
//  3 mute_req=1 at volume 13 -> 10,7,4,1,0. mute=1 on the edge volume hits 0. Never wraps to 255.
//  4 mute_req=1 at 8, drop it at volume 5 -> volume rises 5,8 then IDLE. mute stays 0 throughout.
//  5 In MUTED, vol_req=20 -> volume 0 / mute 1 held. mute_req=0 -> 0,3,...,18,20, then IDLE.
//  6 Assert reset mid-ramp at volume 6 -> next edge volume 0, mute 1, ramping 0, target 8.

Source files
------------

// File: rtl/volume_ctrl_pkg.sv
// Shared state encoding and defaults for the volume ramp controller and its
// output-stage users.
package volume_ctrl_pkg;

   localparam int unsigned DEF_VOL_W = 8;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RAMP     = 3'd1;
   localparam logic [2:0] ST_FADE_OUT = 3'd2;
   localparam logic [2:0] ST_MUTED    = 3'd3;
   localparam logic [2:0] ST_FADE_IN  = 3'd4;

   function automatic logic is_ramp_state(input state_t s);
      return (s == ST_RAMP) || (s == ST_FADE_OUT) || (s == ST_FADE_IN);
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Counts sample ticks and strobes step_en on every TICK_DIV-th tick; held at
// zero while clear is high.
module tick_divider #(
   parameter int unsigned TICK_DIV = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic step_en
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] div_cnt;

   assign step_en = !clear && tick && (div_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= step_en ? '0 : div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/volume_ramp_controller.sv
// Pop-free volume/mute sequencer: ramps the applied volume toward its
// destination in bounded steps paced by the sample tick.
module volume_ramp_controller
   import volume_ctrl_pkg::*;
#(
   parameter int unsigned VOL_W     = DEF_VOL_W,
   parameter int unsigned TICK_DIV  = 16,
   parameter int unsigned STEP      = 1,
   parameter int unsigned RESET_VOL = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_tick,
   input  logic [VOL_W-1:0] vol_req,
   input  logic             vol_req_valid,
   input  logic             mute_req,
   output logic [VOL_W-1:0] volume,
   output logic             mute,
   output logic             ramping
);

   localparam logic [VOL_W:0]   STEP_X    = (VOL_W + 1)'(STEP);
   localparam logic [VOL_W-1:0] RESET_TGT = VOL_W'(RESET_VOL);

   if (TICK_DIV < 1) begin : g_bad_tick_div
      $error("TICK_DIV must be at least 1");
   end
   if (STEP < 1) begin : g_bad_step
      $error("STEP must be at least 1");
   end

   state_t           state;
   state_t           state_next;
   logic [VOL_W-1:0] target;
   logic [VOL_W-1:0] tgt_next;
   logic [VOL_W-1:0] dest;
   logic [VOL_W-1:0] delta;
   logic [VOL_W-1:0] vol_next;
   logic [VOL_W:0]   sdiff;
   logic [VOL_W:0]   mag;
   logic             step_en;
   logic             clear;

   assign clear = !is_ramp_state(state);

   tick_divider #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_divider (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .tick   (sample_tick),
      .step_en(step_en)
   );

   // Signed difference at VOL_W+1 bits; the clamp to |diff| rules out overshoot and wrap.
   always_comb begin
      tgt_next = vol_req_valid ? vol_req : target;
      dest     = (state == ST_FADE_OUT) ? '0 : target;
      sdiff    = {1'b0, dest} - {1'b0, volume};
      mag      = sdiff[VOL_W] ? -sdiff : sdiff;
      delta    = (mag < STEP_X) ? mag[VOL_W-1:0] : STEP_X[VOL_W-1:0];
      vol_next = volume;
      if (step_en) begin
         vol_next = sdiff[VOL_W] ? volume - delta : volume + delta;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (mute_req) begin
               state_next = (volume == '0) ? ST_MUTED : ST_FADE_OUT;
            end else if (vol_req_valid && (vol_req != volume)) begin
               state_next = ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (mute_req) begin
               state_next = ST_FADE_OUT;
            end else if (step_en && (vol_next == tgt_next)) begin
               state_next = ST_IDLE;
            end
         end
         ST_FADE_OUT: begin
            if (!mute_req) begin
               state_next = ST_FADE_IN;
            end else if ((volume == '0) || (step_en && (vol_next == '0))) begin
               state_next = ST_MUTED;
            end
         end
         ST_MUTED: begin
            if (!mute_req) begin
               state_next = ST_FADE_IN;
            end
         end
         ST_FADE_IN: begin
            if (mute_req) begin
               state_next = ST_FADE_OUT;
            end else if ((volume == tgt_next) || (step_en && (vol_next == tgt_next))) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_MUTED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_MUTED;
         volume  <= '0;
         target  <= RESET_TGT;
         mute    <= 1'b1;
         ramping <= 1'b0;
      end else begin
         assert (step_en || (vol_next == volume));
         state   <= state_next;
         volume  <= vol_next;
         target  <= tgt_next;
         mute    <= (state_next == ST_MUTED);
         ramping <= is_ramp_state(state_next);
      end
   end

endmodule

// File: tb/tb_volume_ramp_controller.sv
// Directed bench for volume_ramp_controller with TICK_DIV=4, STEP=3,
// RESET_VOL=8 and a sample tick on every second clock.
module tb_volume_ramp_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sample_tick = 1'b0;
   logic [7:0] vol_req = '0;
   logic       vol_req_valid = 1'b0;
   logic       mute_req = 1'b0;
   logic [7:0] volume;
   logic       mute;
   logic       ramping;

   int n_vec = 0;
   int n_bad = 0;

   // hold>0: apply inputs, outputs must equal expectation for hold cycles.
   // hold==0: wait for the next output change and compare it; ticks/cyc of -1 are not checked.
   typedef struct {
      logic       mute;
      logic       vld;
      logic [7:0] req;
      int         hold;
      logic [7:0] vol;
      logic       mt;
      logic       rmp;
      int         ticks;
      int         cyc;
   } vec_t;

   vec_t vecs[$];

   volume_ramp_controller #(
      .VOL_W    (8),
      .TICK_DIV (4),
      .STEP     (3),
      .RESET_VOL(8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_tick  (sample_tick),
      .vol_req      (vol_req),
      .vol_req_valid(vol_req_valid),
      .mute_req     (mute_req),
      .volume       (volume),
      .mute         (mute),
      .ramping      (ramping)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         sample_tick = ~sample_tick;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d vectors, required completion", n_vec);
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(input logic m, input logic vld, input int req, input int hold,
                               input int vol, input logic mt, input logic rmp,
                               input int tk, input int cy);
      vec_t v;
      v.mute  = m;
      v.vld   = vld;
      v.req   = 8'(req);
      v.hold  = hold;
      v.vol   = 8'(vol);
      v.mt    = mt;
      v.rmp   = rmp;
      v.ticks = tk;
      v.cyc   = cy;
      return v;
   endfunction

   task automatic add(input logic m, input logic vld, input int req, input int hold,
                      input int vol, input logic mt, input logic rmp,
                      input int tk, input int cy);
      vecs.push_back(mk(m, vld, req, hold, vol, mt, rmp, tk, cy));
   endtask

   task automatic chk_out(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got vol=%0d mute=%0b ramping=%0b, expected vol=%0d mute=%0b ramping=%0b",
                  name, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      logic [9:0] expv;
      logic [9:0] prev;
      logic [9:0] bad_val;
      bit         bad;
      bit         seen;
      int         ticks;
      int         cyc;
      expv          = {v.vol, v.mt, v.rmp};
      mute_req      = v.mute;
      vol_req       = v.req;
      vol_req_valid = v.vld;
      if (v.hold > 0) begin
         bad     = 1'b0;
         bad_val = '0;
         for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            vol_req_valid = 1'b0;
            if (!bad && ({volume, mute, ramping} !== expv)) begin
               bad     = 1'b1;
               bad_val = {volume, mute, ramping};
            end
         end
         chk_out({name, ".hold"}, bad ? bad_val : {volume, mute, ramping}, expv);
      end else begin
         prev  = {volume, mute, ramping};
         seen  = 1'b0;
         ticks = 0;
         cyc   = 0;
         while (!seen && (cyc < 40)) begin
            @(posedge clk);
            cyc++;
            if (sample_tick) ticks++;
            #1;
            vol_req_valid = 1'b0;
            if ({volume, mute, ramping} !== prev) seen = 1'b1;
         end
         if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s.timeout: no output change within %0d cycles, expected vol=%0d mute=%0b ramping=%0b",
                     name, cyc, v.vol, v.mt, v.rmp);
         end else begin
            chk_out({name, ".out"}, {volume, mute, ramping}, expv);
            if (v.ticks >= 0) chk_int({name, ".ticks"}, ticks, v.ticks);
            if (v.cyc >= 0) chk_int({name, ".cycles"}, cyc, v.cyc);
         end
      end
   endtask

   initial begin
      // Power-up: fade in from MUTED to the reset target 8
      add(0,0,0,0,   0,0,1,-1, 1);
      add(0,0,0,0,   3,0,1, 4,-1);
      add(0,0,0,0,   6,0,1, 4,-1);
      add(0,0,0,0,   8,0,0, 4,-1);
      // Ramp up to 14, then a single clamped step down to 13
      add(0,1,14,0,  8,0,1,-1, 1);
      add(0,0,0,0,  11,0,1, 4,-1);
      add(0,0,0,0,  14,0,0, 4,-1);
      add(0,1,13,0, 14,0,1,-1, 1);
      add(0,0,0,0,  13,0,0, 4,-1);
      // Mute from 13 down to 0, last step clamps 1 -> 0
      add(1,0,0,0,  13,0,1,-1, 1);
      add(1,0,0,0,  10,0,1, 4,-1);
      add(1,0,0,0,   7,0,1, 4,-1);
      add(1,0,0,0,   4,0,1, 4,-1);
      add(1,0,0,0,   1,0,1, 4,-1);
      add(1,0,0,0,   0,1,0, 4,-1);
      // Unmute with new target 8 latched on the same edge
      add(0,1,8,0,   0,0,1,-1, 1);
      add(0,0,0,0,   3,0,1, 4,-1);
      add(0,0,0,0,   6,0,1, 4,-1);
      add(0,0,0,0,   8,0,0, 4,-1);
      // Fade out reversed at 5: divider keeps counting, back up to 8
      add(1,0,0,0,   8,0,1,-1, 1);
      add(1,0,0,0,   5,0,1, 4,-1);
      add(0,0,0,0,   8,0,0, 4,-1);
      // Full fade out to MUTED
      add(1,0,0,0,   8,0,1,-1, 1);
      add(1,0,0,0,   5,0,1, 4,-1);
      add(1,0,0,0,   2,0,1, 4,-1);
      add(1,0,0,0,   0,1,0, 4,-1);
      // Target written while muted is held, then used on fade-in
      add(1,1,20,20, 0,1,0,-1,-1);
      add(0,0,0,0,   0,0,1,-1, 1);
      add(0,0,0,0,   3,0,1, 4,-1);
      add(0,0,0,0,   6,0,1, 4,-1);
      add(0,0,0,0,   9,0,1, 4,-1);
      add(0,0,0,0,  12,0,1, 4,-1);
      add(0,0,0,0,  15,0,1, 4,-1);
      add(0,0,0,0,  18,0,1, 4,-1);
      add(0,0,0,0,  20,0,0, 4,-1);
      // Ramp down to 0 with a clamped final step
      add(0,1,0,0,  20,0,1,-1, 1);
      add(0,0,0,0,  17,0,1, 4,-1);
      add(0,0,0,0,  14,0,1, 4,-1);
      add(0,0,0,0,  11,0,1, 4,-1);
      add(0,0,0,0,   8,0,1, 4,-1);
      add(0,0,0,0,   5,0,1, 4,-1);
      add(0,0,0,0,   2,0,1, 4,-1);
      add(0,0,0,0,   0,0,0, 4,-1);
      // Request equal to current volume stays idle
      add(0,1,0,12,  0,0,0,-1,-1);
      // Idle at 0 mutes on the next edge; target 0 fade-in goes idle the cycle after
      add(1,0,0,0,   0,1,0,-1, 1);
      add(0,0,0,0,   0,0,1,-1, 1);
      add(0,0,0,0,   0,0,0,-1, 1);
      // Mute outranks a simultaneous request, which is still latched
      add(1,1,9,0,   0,1,0,-1, 1);
      add(0,0,0,0,   0,0,1,-1, 1);
      add(0,0,0,0,   3,0,1, 4,-1);
      add(0,0,0,0,   6,0,1, 4,-1);
      add(0,0,0,0,   9,0,0, 4,-1);

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_out("reset_state", {volume, mute, ramping}, {8'd0, 1'b1, 1'b0});
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset mid-ramp at volume 6, then fade in proves the target was reloaded to 8
      run_vec(mk(0,1,0,0,  9,0,1,-1, 1), "midreset.start");
      run_vec(mk(0,0,0,0,  6,0,1, 4,-1), "midreset.step");
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_out("midreset.reset", {volume, mute, ramping}, {8'd0, 1'b1, 1'b0});
      reset = 1'b0;
      run_vec(mk(0,0,0,0,  0,0,1,-1, 1), "midreset.unmute");
      run_vec(mk(0,0,0,0,  3,0,1, 4,-1), "midreset.s1");
      run_vec(mk(0,0,0,0,  6,0,1, 4,-1), "midreset.s2");
      run_vec(mk(0,0,0,0,  8,0,0, 4,-1), "midreset.s3");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
